// File: rtl/ysyx_22050058_div_ctrl_if.sv
// EXU-side request/response channel of the divide controller.
interface ysyx_22050058_div_ctrl_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic             op_signed_i;
    logic             op_rem_i;
    logic             op_word_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             flush_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [WIDTH-1:0] res_o;

    modport master (
        output in_valid_i, op_signed_i, op_rem_i, op_word_i, src1_i, src2_i,
        output flush_i, res_ready_i,
        input  in_ready_o, res_valid_o, res_o
    );

    modport slave (
        input  in_valid_i, op_signed_i, op_rem_i, op_word_i, src1_i, src2_i,
        input  flush_i, res_ready_i,
        output in_ready_o, res_valid_o, res_o
    );
endinterface

// File: rtl/ysyx_22050058_div_ctrl.sv
// Sign/exception front-end and result back-end around the unsigned divider.
// Handles RV64M div/divu/rem/remu (+W), fast-paths divide-by-zero and overflow.
module ysyx_22050058_div_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ysyx_22050058_div_ctrl_if.slave exu,
    output logic                 div_datavalid_o,
    output logic [WIDTH-1:0]     div_dividend_o,
    output logic [WIDTH-1:0]     div_divisor_o,
    output logic                 div_ready_o,
    input  logic                 div_doing_i,
    input  logic                 div_qrvalid_i,
    input  logic [WIDTH-1:0]     div_quotient_i,
    input  logic [WIDTH-1:0]     div_remainder_i
);
    localparam int unsigned HW = 32;
    localparam int unsigned XW = WIDTH - HW;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [HW-1:0]    MIN_NEG32 = {1'b1, {(HW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLEAR, RESP, DRAIN} state_t;

    state_t           state, state_n;
    logic             res_valid_n, dv_n, rdy_n;
    logic [WIDTH-1:0] res_n, dividend_n, divisor_n;
    logic             neg_q, neg_q_n, neg_r, neg_r_n;
    logic             op_rem, op_rem_n, op_word, op_word_n;
    logic             drop, drop_n;

    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag;
    logic [WIDTH-1:0] fast_sel, fast_res, q_fix, r_fix, slow_sel, slow_res;
    logic             sa, sb, b_zero, ovf, accept;

    function automatic logic [WIDTH-1:0] ext32(input logic [HW-1:0] x, input logic sgn);
        return {{XW{sgn & x[HW-1]}}, x};
    endfunction

    assign exu.in_ready_o = (state == IDLE) & ~exu.flush_i & ~div_doing_i;
    assign accept         = exu.in_valid_i & exu.in_ready_o;

    // Operand extension, magnitudes and fast-path detection.
    always_comb begin
        a_ext  = exu.op_word_i ? ext32(exu.src1_i[HW-1:0], exu.op_signed_i) : exu.src1_i;
        b_ext  = exu.op_word_i ? ext32(exu.src2_i[HW-1:0], exu.op_signed_i) : exu.src2_i;
        sa     = exu.op_signed_i & a_ext[WIDTH-1];
        sb     = exu.op_signed_i & b_ext[WIDTH-1];
        a_mag  = sa ? WIDTH'(-a_ext) : a_ext;
        b_mag  = sb ? WIDTH'(-b_ext) : b_ext;
        b_zero = (b_ext == '0);
        ovf    = exu.op_signed_i &
                 (exu.op_word_i ? ((exu.src1_i[HW-1:0] == MIN_NEG32) && (exu.src2_i[HW-1:0] == '1))
                                : ((exu.src1_i == MIN_NEG) && (exu.src2_i == '1)));
        if (exu.op_rem_i) fast_sel = b_zero ? a_ext : '0;
        else              fast_sel = b_zero ? '1 : a_ext;
        fast_res = exu.op_word_i ? ext32(fast_sel[HW-1:0], 1'b1) : fast_sel;
    end

    // Sign correction and W truncation of the divider result.
    always_comb begin
        q_fix    = neg_q ? WIDTH'(-div_quotient_i) : div_quotient_i;
        r_fix    = neg_r ? WIDTH'(-div_remainder_i) : div_remainder_i;
        slow_sel = op_rem ? r_fix : q_fix;
        slow_res = op_word ? ext32(slow_sel[HW-1:0], 1'b1) : slow_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            exu.res_valid_o <= 1'b0;
            exu.res_o       <= '0;
            div_datavalid_o <= 1'b0;
            div_ready_o     <= 1'b0;
            div_dividend_o  <= '0;
            div_divisor_o   <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            op_rem          <= 1'b0;
            op_word         <= 1'b0;
            drop            <= 1'b0;
        end else begin
            state           <= state_n;
            exu.res_valid_o <= res_valid_n;
            exu.res_o       <= res_n;
            div_datavalid_o <= dv_n;
            div_ready_o     <= rdy_n;
            div_dividend_o  <= dividend_n;
            div_divisor_o   <= divisor_n;
            neg_q           <= neg_q_n;
            neg_r           <= neg_r_n;
            op_rem          <= op_rem_n;
            op_word         <= op_word_n;
            drop            <= drop_n;
        end
    end

    // drop marks an abandoned op whose divider result must still be cleared.
    always_comb begin
        state_n     = state;
        res_valid_n = exu.res_valid_o;
        res_n       = exu.res_o;
        dv_n        = 1'b0;
        rdy_n       = 1'b0;
        dividend_n  = div_dividend_o;
        divisor_n   = div_divisor_o;
        neg_q_n     = neg_q;
        neg_r_n     = neg_r;
        op_rem_n    = op_rem;
        op_word_n   = op_word;
        drop_n      = drop;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_rem_n  = exu.op_rem_i;
                    op_word_n = exu.op_word_i;
                    if (b_zero || ovf) begin
                        res_n       = fast_res;
                        res_valid_n = 1'b1;
                        state_n     = RESP;
                    end else begin
                        dividend_n = a_mag;
                        divisor_n  = b_mag;
                        neg_q_n    = sa ^ sb;
                        neg_r_n    = sa;
                        dv_n       = 1'b1;
                        state_n    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_n = exu.flush_i ? DRAIN : WAIT;
                drop_n  = exu.flush_i;
            end
            WAIT: begin
                if (div_qrvalid_i) begin
                    res_n   = slow_res;
                    rdy_n   = 1'b1;
                    drop_n  = exu.flush_i;
                    state_n = CLEAR;
                end else if (exu.flush_i) begin
                    drop_n  = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (div_qrvalid_i) begin
                    rdy_n   = 1'b1;
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                drop_n = 1'b0;
                if (exu.flush_i || drop) begin
                    state_n = IDLE;
                end else begin
                    res_valid_n = 1'b1;
                    state_n     = RESP;
                end
            end
            RESP: begin
                if (exu.flush_i || exu.res_ready_i) begin
                    res_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ysyx_22050058_div_ctrl.sv
// Scoreboard bench for ysyx_22050058_div_ctrl with a behavioural divider model.
module tb_ysyx_22050058_div_ctrl;
    localparam int unsigned W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050058_div_ctrl_if #(.WIDTH(W)) exu();

    logic         div_datavalid, div_ready, div_doing, div_qrvalid;
    logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;

    ysyx_22050058_div_ctrl #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .exu             (exu),
        .div_datavalid_o (div_datavalid),
        .div_dividend_o  (div_dividend),
        .div_divisor_o   (div_divisor),
        .div_ready_o     (div_ready),
        .div_doing_i     (div_doing),
        .div_qrvalid_i   (div_qrvalid),
        .div_quotient_i  (div_quotient),
        .div_remainder_i (div_remainder)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
        else n_pass++;
    endtask

    // Divider model: random latency, holds q/r until the clear pulse.
    logic [W-1:0] m_a, m_b;
    int unsigned  m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_doing <= 1'b0; div_qrvalid <= 1'b0;
            div_quotient <= '0; div_remainder <= '0;
            m_cnt <= 0; m_a <= '0; m_b <= '0;
        end else begin
            if (div_ready) div_qrvalid <= 1'b0;
            if (div_datavalid && !div_doing && !div_qrvalid) begin
                div_doing <= 1'b1;
                m_cnt     <= $urandom_range(2, 9);
                m_a       <= div_dividend;
                m_b       <= div_divisor;
            end else if (div_doing) begin
                if (m_cnt == 0) begin
                    div_doing     <= 1'b0;
                    div_qrvalid   <= 1'b1;
                    div_quotient  <= (m_b == '0) ? '1 : m_a / m_b;
                    div_remainder <= (m_b == '0) ? m_a : m_a % m_b;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    int unsigned cyc = 0, dv_cnt = 0, rdy_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_datavalid) dv_cnt <= dv_cnt + 1;
        if (div_ready) rdy_cnt <= rdy_cnt + 1;
    end

    // Reference: RISC-V M-extension semantics in plain integer arithmetic.
    function automatic logic [63:0] ref_div(input bit sg, input bit rm, input bit wd,
                                            input logic [63:0] s1, input logic [63:0] s2,
                                            output bit fast);
        int a32, b32;
        int unsigned ua32, ub32;
        longint a64, b64;
        longint unsigned ua64, ub64;
        logic [31:0] w;
        logic [63:0] r;
        fast = 1'b0;
        if (wd) begin
            if (sg) begin
                a32 = s1[31:0]; b32 = s2[31:0];
                if (b32 == 0) begin fast = 1'b1; w = rm ? a32 : '1; end
                else if (a32 == int'(32'h8000_0000) && b32 == -1) begin fast = 1'b1; w = rm ? '0 : a32; end
                else w = rm ? 32'(a32 % b32) : 32'(a32 / b32);
            end else begin
                ua32 = s1[31:0]; ub32 = s2[31:0];
                if (ub32 == 0) begin fast = 1'b1; w = rm ? ua32 : '1; end
                else w = rm ? 32'(ua32 % ub32) : 32'(ua32 / ub32);
            end
            r = {{32{w[31]}}, w};
        end else if (sg) begin
            a64 = s1; b64 = s2;
            if (b64 == 0) begin fast = 1'b1; r = rm ? s1 : '1; end
            else if (s1 == 64'h8000_0000_0000_0000 && s2 == '1) begin fast = 1'b1; r = rm ? '0 : s1; end
            else r = rm ? 64'(a64 % b64) : 64'(a64 / b64);
        end else begin
            ua64 = s1; ub64 = s2;
            if (ub64 == 0) begin fast = 1'b1; r = rm ? s1 : '1; end
            else r = rm ? 64'(ua64 % ub64) : 64'(ua64 / ub64);
        end
        return r;
    endfunction

    typedef struct {
        logic [63:0] exp;
        bit          fast;
        int unsigned acc;
    } sb_t;
    sb_t sbq[$];

    // Monitor: latency, hold-while-stalled, result compare, issue guard.
    bit          prev_rv, prev_qr, stall;
    logic [63:0] stall_res;
    int unsigned qr_rise;
    sb_t         mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0; prev_qr = 1'b0; stall = 1'b0;
        end else begin
            if (div_qrvalid && !prev_qr) qr_rise = cyc;
            if (div_datavalid)
                check("issue_guard", {62'b0, div_doing, (div_divisor == '0)}, 64'd0);
            if (stall) begin
                check("stall_valid", 64'(exu.res_valid_o), 64'd1);
                check("stall_res", exu.res_o, stall_res);
            end
            if (exu.res_valid_o && !prev_rv) begin
                if (sbq.size() == 0) check("unexpected_valid", 64'(exu.res_valid_o), 64'd0);
                else if (sbq[0].fast) check("fast_latency", 64'(cyc - sbq[0].acc), 64'd1);
                else check("slow_latency", 64'(cyc - qr_rise), 64'd2);
            end
            if (exu.res_valid_o && exu.res_ready_i) begin
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    check("result", exu.res_o, mon_e.exp);
                end
                stall = 1'b0;
            end else begin
                stall     = exu.res_valid_o && !exu.flush_i;
                stall_res = exu.res_o;
            end
            prev_rv = exu.res_valid_o;
            prev_qr = div_qrvalid;
        end
    end

    int rdy_mode = 1;   // 0 low, 1 high, 2 random
    always @(posedge clk) begin
        #1;
        exu.res_ready_i = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 9) < 7);
    end

    task automatic issue(input bit sg, input bit rm, input bit wd, input logic [63:0] s1,
                         input logic [63:0] s2, input bit track, input logic [63:0] exp,
                         input bit fast);
        int unsigned n = 0;
        @(posedge clk); #1;
        exu.op_signed_i = sg; exu.op_rem_i = rm; exu.op_word_i = wd;
        exu.src1_i = s1; exu.src2_i = s2; exu.in_valid_i = 1'b1;
        do begin @(negedge clk); n++; end while (!exu.in_ready_o && n < 500);
        check("accept", 64'(exu.in_ready_o), 64'd1);
        if (track) sbq.push_back('{exp, fast, cyc});
        @(posedge clk); #1;
        exu.in_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sbq.size() != 0 || exu.res_valid_o) && n < 1000) begin @(negedge clk); n++; end
        check("drain", 64'(sbq.size()), 64'd0);
    endtask

    task automatic dir_op(input bit sg, input bit rm, input bit wd, input logic [63:0] s1,
                          input logic [63:0] s2, input logic [63:0] exp, input bit fast);
        int unsigned d0, r0;
        d0 = dv_cnt; r0 = rdy_cnt;
        issue(sg, rm, wd, s1, s2, 1'b1, exp, fast);
        wait_idle();
        check("dv_pulses", 64'(dv_cnt - d0), fast ? 64'd0 : 64'd1);
        check("clr_pulses", 64'(rdy_cnt - r0), fast ? 64'd0 : 64'd1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 8))
            0, 1:    return {$urandom, $urandom};
            2:       return 64'($urandom_range(0, 1000));
            3:       return -64'($urandom_range(1, 1000));
            4:       return '0;
            5:       return '1;
            6:       return 64'h8000_0000_0000_0000;
            7:       return {$urandom, 32'hFFFF_FFFF};
            default: return {$urandom, 32'h8000_0000};
        endcase
    endfunction

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit sg, rm, wd, fast, seen, bad;
        logic [63:0] s1, s2, e;
        int unsigned n, d0;
        exu.in_valid_i = 1'b0; exu.flush_i = 1'b0;
        exu.op_signed_i = 1'b0; exu.op_rem_i = 1'b0; exu.op_word_i = 1'b0;
        exu.src1_i = '0; exu.src2_i = '0;
        #1;
        check("rst_res_valid", 64'(exu.res_valid_o), 64'd0);
        check("rst_datavalid", 64'(div_datavalid), 64'd0);
        check("rst_clr", 64'(div_ready), 64'd0);
        check("rst_res", exu.res_o, 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        dir_op(1, 0, 0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        dir_op(1, 1, 0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        dir_op(0, 0, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        dir_op(0, 1, 0, 64'h1234, 64'd0, 64'h1234, 1);
        dir_op(1, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        dir_op(1, 1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
        dir_op(1, 0, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        dir_op(0, 0, 1, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 0);

        // Flush while waiting on the divider.
        issue(0, 0, 0, 64'd1000, 64'd3, 1'b0, '0, 1'b0);
        @(posedge clk); #1 exu.flush_i = 1'b1;
        @(posedge clk); #1 exu.flush_i = 1'b0;
        seen = 1'b0; bad = 1'b0; n = 0;
        while (!seen && n < 100) begin
            @(negedge clk); n++;
            if (exu.in_ready_o) bad = 1'b1;
            if (div_ready) seen = 1'b1;
        end
        check("flush_clr_pulse", 64'(seen), 64'd1);
        check("flush_busy", 64'(bad), 64'd0);
        check("flush_no_result", 64'(exu.res_valid_o), 64'd0);
        @(negedge clk);
        check("flush_ready_after", 64'(exu.in_ready_o), 64'd1);
        dir_op(0, 0, 0, 64'd100, 64'd7, 64'd14, 0);

        // Flush beats a simultaneous request.
        d0 = dv_cnt;
        @(posedge clk); #1;
        exu.in_valid_i = 1'b1; exu.flush_i = 1'b1; exu.src1_i = 64'd9; exu.src2_i = 64'd2;
        @(negedge clk);
        check("flush_blocks_accept", 64'(exu.in_ready_o), 64'd0);
        @(posedge clk); #1 exu.in_valid_i = 1'b0; exu.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_no_issue", 64'(dv_cnt - d0), 64'd0);
        check("flush_no_valid", 64'(exu.res_valid_o), 64'd0);

        // Back-pressure in RESP.
        rdy_mode = 0;
        issue(1, 1, 0, -64'd100, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        n = 0;
        while (!exu.res_valid_o && n < 100) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        check("stall_hold", 64'(exu.res_valid_o), 64'd1);
        rdy_mode = 1;
        wait_idle();

        // Asynchronous reset mid-divide.
        issue(0, 0, 0, 64'd1000, 64'd3, 1'b0, '0, 1'b0);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("amid_res_valid", 64'(exu.res_valid_o), 64'd0);
        check("amid_datavalid", 64'(div_datavalid), 64'd0);
        check("amid_clr", 64'(div_ready), 64'd0);
        check("amid_res", exu.res_o, 64'd0);
        check("amid_dividend", div_dividend, 64'd0);
        check("amid_divisor", div_divisor, 64'd0);
        check("amid_in_ready", 64'(exu.in_ready_o), 64'd1);
        @(posedge clk); #3 rst_n = 1'b1;

        // Randomised traffic with random back-pressure.
        rdy_mode = 2;
        repeat (300) begin
            sg = 1'($urandom); rm = 1'($urandom); wd = 1'($urandom);
            s1 = pick(); s2 = pick();
            e = ref_div(sg, rm, wd, s1, s2, fast);
            issue(sg, rm, wd, s1, s2, 1'b1, e, fast);
        end
        rdy_mode = 1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ysyx_22050058_div_ctrl.md
Name: ysyx_22050058_div_ctrl

Overview:
- Sign/exception front-end and result back-end for the unsigned pipelined divider `ysyx_22050058_div`.
- Accepts RV64M divide ops from EXU: div, divu, rem, remu and their W variants.
- Converts operands to unsigned magnitudes, issues them to the divider, and waits for the quotient/remainder.
- Applies sign correction and W-truncation, then returns one result to EXU over a valid/ready handshake.
- Divide-by-zero and signed overflow bypass the divider entirely.

Parameters:
- WIDTH, 64, datapath width; must equal the divider's WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  EXU presents a divide op
- in_ready_o  out  1  block can accept an op this cycle
- op_signed_i  in  1  1 = div/rem(w); 0 = divu/remu(w)
- op_rem_i  in  1  1 = return remainder; 0 = return quotient
- op_word_i  in  1  1 = W variant: 32-bit operands, sign-extended result
- src1_i  in  WIDTH  dividend
- src2_i  in  WIDTH  divisor
- flush_i  in  1  pipeline flush: abandon the current op
- res_valid_o  out  1  result available
- res_ready_i  in  1  EXU takes the result
- res_o  out  WIDTH  final result
- div_datavalid_o  out  1  to divider div_datavalid_i
- div_dividend_o  out  WIDTH  unsigned dividend magnitude
- div_divisor_o  out  WIDTH  unsigned divisor magnitude, never zero
- div_ready_o  out  1  to divider div_ready: one-cycle pulse that clears its held outputs
- div_doing_i  in  1  from divider div_doing_o
- div_qrvalid_i  in  1  from divider div_qrvalid_o
- div_quotient_i  in  WIDTH  from divider
- div_remainder_i  in  WIDTH  from divider

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - res_valid_o, div_datavalid_o, div_ready_o = 0.
  - res_o, div_dividend_o, div_divisor_o = 0.
  - Reset mid-operation discards everything. The divider is reset from the same source (inverted at top level).
- Handshakes:
  - in_ready_o = (state==IDLE) & ~flush_i & ~div_doing_i.
  - Accept occurs when in_valid_i & in_ready_o.
  - Result transfer occurs when res_valid_o & res_ready_i.
- Operand preparation at accept, registered:
  - W ops: a = sext(src1[31:0]) if signed, else zext(src1[31:0]); b likewise from src2. Non-W ops: a = src1, b = src2.
  - Signed ops: magnitude = two's-complement negate when the sign bit is set. abs(most-negative) = 2^(WIDTH-1), which is valid unsigned.
  - Record neg_q = sa ^ sb and neg_r = sa, where sa/sb are the operand sign bits (signed only).
- Fast path: no divider issue.
  - b == 0: quotient = all ones; remainder = a.
  - Signed overflow (non-W: a = 0x8000..0 and b = all ones; W: a[31:0] = 0x80000000 and b[31:0] = 0xFFFFFFFF): quotient = a, remainder = 0.
  - State goes IDLE -> RESP; res_valid_o is high the cycle after accept.
- FSM states: IDLE, ISSUE, WAIT, CLEAR, RESP, DRAIN.
  - IDLE -> ISSUE on a normal accept.
  - ISSUE: div_datavalid_o = 1 for exactly one cycle -> WAIT.
  - WAIT: when div_qrvalid_i is sampled high, compute and register res_o -> CLEAR.
  - CLEAR: div_ready_o = 1 for one cycle, res_valid_o = 1 -> RESP.
  - RESP: res_valid_o held high, res_o stable until transfer -> IDLE.
- Result formation in WAIT:
  - q = neg_q ? -div_quotient_i : div_quotient_i.
  - r = neg_r ? -div_remainder_i : div_remainder_i.
  - Select q or r by op_rem. For W ops, res_o = sext(sel[31:0]).
- Flush:
  - In ISSUE or WAIT: go to DRAIN (div_datavalid_o still completes its pulse if already in ISSUE). DRAIN waits for div_qrvalid_i, pulses div_ready_o, then goes to IDLE. No res_valid_o is produced.
  - In CLEAR: the div_ready_o pulse still occurs; go to IDLE. No res_valid_o.
  - In RESP: res_valid_o drops next cycle; go to IDLE.
  - Flush in IDLE together with in_valid_i: flush wins, no accept.
- Latency: normal path res_valid_o asserts two cycles after div_qrvalid_i first rises. Throughput is one op in flight.
- At most one divider op is outstanding; div_datavalid_o never pulses while div_doing_i = 1.

Test Plan:
- Signed div, src1=-7, src2=2 -> res_o=0xFFFF_FFFF_FFFF_FFFD. Same with op_rem=1 -> 0xFFFF_FFFF_FFFF_FFFF. One div_datavalid_o pulse, one div_ready_o pulse.
- divu src1=0x1234, src2=0 -> 0xFFFF_FFFF_FFFF_FFFF one cycle after accept. remu same operands -> 0x1234. div_datavalid_o never asserted.
- Signed div 0x8000_0000_0000_0000 / all-ones -> 0x8000_0000_0000_0000. remw src1=0x8000_0000, src2=0xFFFF_FFFF -> 0. Both on the fast path.
- divw src1=0x0000_0000_FFFF_FFF9, src2=2 -> 0xFFFF_FFFF_FFFF_FFFD. divuw src1=0xFFFF_FFFF_8000_0000, src2=2 -> 0x0000_0000_4000_0000.
- flush_i during WAIT -> no res_valid_o, in_ready_o low until div_qrvalid_i and div_ready_o pulse. Next op 100/7 -> 14, correct.
- res_ready_i low for 5 cycles in RESP -> res_o and res_valid_o stable. Separately, rst_n low mid-WAIT -> all outputs 0 immediately, state IDLE.
